// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and counter sizing shared by the serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done request and result bundle of the serial subtractor.
// Carries the signed-overflow flag V only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);

    logic             Start;
    logic [WIDTH-1:0] DataA;
    logic [WIDTH-1:0] DataB;
    logic             Bin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             V;
`endif

    modport master (
`ifdef SERIAL_SUB_OVERFLOW_EN
        input  V,
`endif
        output Start, DataA, DataB, Bin,
        input  Busy, Done, Diff, Bout
    );

    modport slave (
`ifdef SERIAL_SUB_OVERFLOW_EN
        output V,
`endif
        input  Start, DataA, DataB, Bin,
        output Busy, Done, Diff, Bout
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: combinational single-bit cell computing a - b - bin with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, one bit per clock LSB first, start/done handshake.
// Optional signed-overflow output V is built when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    serial_subtractor_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, diff_q;
    logic             bor, bout_q;
    logic             fs_d, fs_bout;
    logic             accept, last;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bor),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Start is only honoured outside SHIFT, which makes DONE->SHIFT back-to-back legal
    assign accept = (state != SHIFT) && bus.Start;
    assign last   = (state == SHIFT) && (count == CW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        state_nx = accept ? SHIFT :
                   last ? DONE :
                   (state == DONE) ? IDLE : state;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bor    <= 1'b0;
            count  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.DataA;
            b_sr  <= bus.DataB;
            bor   <= bus.Bin;
            count <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            bor    <= fs_bout;
            res_sr <= {fs_d, res_sr[WIDTH-1:1]};
            count  <= count + 1'b1;
            if (last) begin
                diff_q <= {fs_d, res_sr[WIDTH-1:1]};
                bout_q <= fs_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Operand MSBs are kept because the shift registers have consumed them by completion
    logic a_msb, b_msb, v_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            v_q   <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.DataA[WIDTH-1];
            b_msb <= bus.DataB[WIDTH-1];
        end else if (last) begin
            v_q <= (a_msb ^ b_msb) & (a_msb ^ fs_d);
        end
    end

    assign bus.V = v_q;
`endif

    assign bus.Busy = (state == SHIFT);
    assign bus.Done = (state == DONE);
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random self-checking bench for serial_subtractor.
// Overflow checks are included when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    serial_subtractor_if #(.WIDTH(8)) bus_i ();

    serial_subtractor #(.WIDTH(8)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus_i)
    );

    always #5 clk = ~clk;

    // Launches one operation and returns the number of edges after the Start edge until Done
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin, output int cyc);
        @(negedge clk);
        bus_i.Start = 1'b1;
        bus_i.DataA = a;
        bus_i.DataB = b;
        bus_i.Bin   = bin;
        @(posedge clk);
        @(negedge clk);
        bus_i.Start = 1'b0;
        cyc = 0;
        while (!bus_i.Done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus_i.Start = 1'b0;
        bus_i.DataA = 8'h00;
        bus_i.DataB = 8'h00;
        bus_i.Bin   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_i.Busy, bus_i.Done, bus_i.Bout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000", {bus_i.Busy, bus_i.Done, bus_i.Bout});
        end
        checks++;
        if (bus_i.Diff !== 8'h00) begin
            errors++;
            $display("FAIL reset_diff got=%h exp=00", bus_i.Diff);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        do_op(8'h5A, 8'h3C, 1'b0, cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=8", cyc);
        end
        checks++;
        if ({bus_i.Diff, bus_i.Bout} !== {8'h1E, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got=%h/%b exp=1e/0", bus_i.Diff, bus_i.Bout);
        end
        @(negedge clk);
        checks++;
        if (bus_i.Done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width got=%b exp=0", bus_i.Done);
        end
        checks++;
        if (bus_i.Diff !== 8'h1E) begin
            errors++;
            $display("FAIL basic_hold got=%h exp=1e", bus_i.Diff);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] a_t [4] = '{8'h00, 8'h10, 8'h00, 8'hFF};
        logic [7:0] b_t [4] = '{8'h01, 8'h0F, 8'h00, 8'hFF};
        logic       c_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [8:0] e_t [4] = '{{8'hFF, 1'b1}, {8'h00, 1'b0}, {8'hFF, 1'b1}, {8'h00, 1'b0}};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            do_op(a_t[i], b_t[i], c_t[i], cyc);
            checks++;
            if (cyc !== 8 || {bus_i.Diff, bus_i.Bout} !== e_t[i]) begin
                errors++;
                $display("FAIL wrap_%0d got=%h/%b cyc=%0d exp=%h/%b cyc=8", i,
                         bus_i.Diff, bus_i.Bout, cyc, e_t[i][8:1], e_t[i][0]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        bit busy_ok = 1'b1;
        bit hold_ok = 1'b1;
        logic [7:0] prev;
        prev = bus_i.Diff;
        @(negedge clk);
        bus_i.Start = 1'b1;
        bus_i.DataA = 8'h5A;
        bus_i.DataB = 8'h3C;
        bus_i.Bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_i.Start = 1'b0;
        cyc = 0;
        while (!bus_i.Done && cyc < 40) begin
            if (!bus_i.Busy) busy_ok = 1'b0;
            if (bus_i.Diff !== prev) hold_ok = 1'b0;
            bus_i.Start = (cyc == 3);
            if (cyc == 3) begin
                bus_i.DataA = 8'h01;
                bus_i.DataB = 8'hF0;
                bus_i.Bin   = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy got=%b exp=1", busy_ok);
        end
        checks++;
        if (hold_ok !== 1'b1) begin
            errors++;
            $display("FAIL ignore_diff_hold got=%b exp=1", hold_ok);
        end
        checks++;
        if (cyc !== 8 || {bus_i.Diff, bus_i.Bout} !== {8'h1E, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result got=%h/%b cyc=%0d exp=1e/0 cyc=8", bus_i.Diff, bus_i.Bout, cyc);
        end
        @(negedge clk);
        checks++;
        if ({bus_i.Busy, bus_i.Done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_idle got=%b exp=00", {bus_i.Busy, bus_i.Done});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int cyc2;
        @(negedge clk);
        bus_i.Start = 1'b1;
        bus_i.DataA = 8'h5A;
        bus_i.DataB = 8'h3C;
        bus_i.Bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (!bus_i.Done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 8 || bus_i.Diff !== 8'h1E) begin
            errors++;
            $display("FAIL b2b_first got=%h cyc=%0d exp=1e cyc=8", bus_i.Diff, cyc);
        end
        bus_i.DataA = 8'h00;
        bus_i.DataB = 8'h01;
        cyc2 = 0;
        do begin
            @(negedge clk);
            cyc2++;
            bus_i.Start = 1'b0;
        end while (!bus_i.Done && cyc2 < 40);
        checks++;
        if (cyc2 !== 9) begin
            errors++;
            $display("FAIL b2b_latency got=%0d exp=9", cyc2);
        end
        checks++;
        if ({bus_i.Diff, bus_i.Bout} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second got=%h/%b exp=ff/1", bus_i.Diff, bus_i.Bout);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit no_done = 1'b1;
        @(negedge clk);
        bus_i.Start = 1'b1;
        bus_i.DataA = 8'h5A;
        bus_i.DataB = 8'h3C;
        bus_i.Bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_i.Start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_i.Busy, bus_i.Done, bus_i.Bout, bus_i.Diff} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b/%b/%b/%h exp=0/0/0/00", bus_i.Busy, bus_i.Done, bus_i.Bout, bus_i.Diff);
        end
        repeat (12) begin
            @(negedge clk);
            if (bus_i.Done) no_done = 1'b0;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus_i.Done) no_done = 1'b0;
        end
        checks++;
        if (no_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_done got=%b exp=1", no_done);
        end
        do_op(8'h5A, 8'h3C, 1'b0, cyc);
        checks++;
        if (cyc !== 8 || {bus_i.Diff, bus_i.Bout} !== {8'h1E, 1'b0}) begin
            errors++;
            $display("FAIL reset_recover got=%h/%b cyc=%0d exp=1e/0 cyc=8", bus_i.Diff, bus_i.Bout, cyc);
        end
    endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
    task automatic test_overflow();
        int cyc;
        do_op(8'h80, 8'h01, 1'b0, cyc);
        checks++;
        if ({bus_i.Diff, bus_i.V, bus_i.Bout} !== {8'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ovf_set got=%h/%b/%b exp=7f/1/0", bus_i.Diff, bus_i.V, bus_i.Bout);
        end
        do_op(8'h05, 8'h03, 1'b0, cyc);
        checks++;
        if ({bus_i.Diff, bus_i.V} !== {8'h02, 1'b0}) begin
            errors++;
            $display("FAIL ovf_clear got=%h/%b exp=02/0", bus_i.Diff, bus_i.V);
        end
    endtask
`endif

    task automatic test_random();
        int cyc;
        logic [7:0] a, b, d;
        logic       c, bo;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            d = a - b - {7'd0, c};
            bo = ({1'b0, a} < ({1'b0, b} + {8'd0, c}));
            do_op(a, b, c, cyc);
            checks++;
            if (cyc !== 8 || {bus_i.Diff, bus_i.Bout} !== {d, bo}) begin
                errors++;
                $display("FAIL rand_%0d a=%h b=%h bin=%b got=%h/%b cyc=%0d exp=%h/%b", i, a, b, c,
                         bus_i.Diff, bus_i.Bout, cyc, d, bo);
            end
`ifdef SERIAL_SUB_OVERFLOW_EN
            checks++;
            if (bus_i.V !== ((a[7] ^ b[7]) & (a[7] ^ d[7]))) begin
                errors++;
                $display("FAIL rand_v_%0d got=%b exp=%b", i, bus_i.V, (a[7] ^ b[7]) & (a[7] ^ d[7]));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_SUB_OVERFLOW_EN
        test_overflow();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
